// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, FSM encoding and pin idle levels for sram_responder.
package sram_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;
    localparam logic ACT_HI_OFF = 1'b0;
    localparam logic ACT_LO_OFF = 1'b1;
endpackage

// File: rtl/sram_responder_sync_edge.sv
// sync_edge: optional two-flop synchronizer (SRAM_RESPONDER_SYNC_EN) plus previous-value register.
// Outputs the synchronized level and its rise/fall relative to the previous cycle.
module sync_edge #(
    parameter int            W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] lvl,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);
    logic [W-1:0] prev_q;
`ifdef SRAM_RESPONDER_SYNC_EN
    logic [W-1:0] s1_q, s2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end
    assign lvl = s2_q;
`else
    assign lvl = d;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= RST_VAL;
        else        prev_q <= lvl;
    end
    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;
endmodule

// File: rtl/sram_responder.sv
// sram_responder: SRAM board model (address counter, data latch, async array) answering the controller's pins.
// Define SRAM_RESPONDER_SYNC_EN to put a two-flop synchronizer on every pin input.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              count,
    input  logic              latch,
    input  logic              de,
    input  logic              n_de,
    input  logic              n_ce,
    input  logic              n_oe,
    input  logic              n_we,
    input  logic              rst,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic [ADDR_W-1:0] addr,
    output logic              contention
);
    localparam int NP = 9;
    localparam logic [NP-1:0] PIN_OFF = {ACT_LO_OFF, ACT_HI_OFF, ACT_LO_OFF, ACT_LO_OFF, ACT_LO_OFF,
                                         ACT_LO_OFF, ACT_HI_OFF, ACT_HI_OFF, ACT_HI_OFF};
    logic [NP-1:0] pin, s_lvl, s_rise, s_fall;
    logic [DATA_W-1:0] s_data_in, d_rise, d_fall;
    assign pin = {n_rst, rst, n_we, n_oe, n_ce, n_de, de, latch, count};

    for (genvar i = 0; i < NP; i++) begin : g_pin
        sync_edge #(.W(1), .RST_VAL(PIN_OFF[i])) u_sync (
            .clk(clock), .rst_n(n_reset), .d(pin[i]),
            .lvl(s_lvl[i]), .rise(s_rise[i]), .fall(s_fall[i])
        );
    end

    sync_edge #(.W(DATA_W), .RST_VAL('0)) u_sync_data (
        .clk(clock), .rst_n(n_reset), .d(data_in),
        .lvl(s_data_in), .rise(d_rise), .fall(d_fall)
    );

    logic s_de, s_n_de, s_n_ce, s_n_oe, s_n_we, s_rst, s_n_rst;
    assign {s_n_rst, s_rst, s_n_we, s_n_oe, s_n_ce, s_n_de, s_de} = s_lvl[8:2];

    state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, waddr_q, waddr_d;
    logic [DATA_W-1:0] hold_q, hold_d, data_out_q, data_out_d;
    logic data_oe_q, data_oe_d, contention_q, contention_d, mem_we, go_write;
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    assign go_write = !s_n_ce && !s_n_we;

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_write) begin
                    state_d = WRITE;
                    waddr_d = addr_q;
                end else if (!s_n_ce && !s_n_oe) state_d = READ;
            end
            READ: begin
                if (go_write) begin
                    state_d = WRITE;
                    waddr_d = addr_q;
                end else if (s_n_ce || s_n_oe) state_d = IDLE;
            end
            WRITE: begin
                if (s_n_we || s_n_ce) begin
                    mem_we  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear beats a coincident count edge.
    always_comb begin
        addr_d       = (s_rst || !s_n_rst) ? '0 : s_rise[0] ? addr_q + 1'b1 : addr_q;
        hold_d       = s_rise[1] ? s_data_in : hold_q;
        data_oe_d    = state_q == READ;
        data_out_d   = state_q == READ ? mem_q[addr_q] : data_out_q;
        contention_d = contention_q | (data_oe_q & (s_de | ~s_n_de));
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            waddr_q      <= '0;
            hold_q       <= '0;
            data_out_q   <= '0;
            data_oe_q    <= 1'b0;
            contention_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            waddr_q      <= waddr_d;
            hold_q       <= hold_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            contention_q <= contention_d;
        end
    end

    // State is forced to IDLE during reset, so an interrupted write never commits.
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[waddr_q] <= hold_q;
    end

    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;
    assign addr       = addr_q;
    assign contention = contention_q;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed + randomized checks of sram_responder against an array/counter reference model.
module tb_sram_responder;
`ifdef SRAM_RESPONDER_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif
    logic clock = 1'b0, n_reset = 1'b0;
    logic count = 1'b0, latch = 1'b0, de = 1'b0, n_de = 1'b1, n_ce = 1'b1;
    logic n_oe = 1'b1, n_we = 1'b1, rst = 1'b0, n_rst = 1'b1;
    logic [7:0] data_in = 8'h00, data_out, addr;
    logic data_oe, contention;

    sram_responder #(.ADDR_W(8), .DATA_W(8)) dut (
        .clock(clock), .n_reset(n_reset), .count(count), .latch(latch), .de(de), .n_de(n_de),
        .n_ce(n_ce), .n_oe(n_oe), .n_we(n_we), .rst(rst), .n_rst(n_rst), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .addr(addr), .contention(contention)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_fail = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] ref_addr = 8'd0;
    logic ref_cont = 1'b0;
    logic [7:0] rnd_a [6];
    logic [7:0] rnd_d [6];

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_count();
        count = 1'b1;
        step(2);
        count = 1'b0;
        step(2);
        ref_addr = ref_addr + 8'd1;
    endtask

    task automatic clear_addr();
        rst = 1'b1;
        count = 1'b1;
        step(L + 2);
        rst = 1'b0;
        count = 1'b0;
        step(L + 2);
        ref_addr = 8'd0;
    endtask

    task automatic set_addr(input logic [7:0] a);
        clear_addr();
        for (int i = 0; i < int'(a); i++) pulse_count();
        step(L + 1);
    endtask

    task automatic load_hold(input logic [7:0] d);
        data_in = d;
        step(1);
        latch = 1'b1;
        step(2);
        latch = 1'b0;
        step(L + 2);
    endtask

    task automatic write_word(input logic [7:0] a, input logic [7:0] d);
        set_addr(a);
        load_hold(d);
        n_ce = 1'b0;
        n_we = 1'b0;
        step(L + 3);
        n_we = 1'b1;
        step(L + 3);
        n_ce = 1'b1;
        step(L + 2);
        ref_mem[a] = d;
    endtask

    task automatic read_here(input string tag);
        n_ce = 1'b0;
        n_oe = 1'b0;
        step(L + 1);
        check({tag, "_oe_pre"}, {31'd0, data_oe}, 32'd0);
        step(1);
        check({tag, "_oe"}, {31'd0, data_oe}, 32'd1);
        check({tag, "_data"}, {24'd0, data_out}, {24'd0, ref_mem[ref_addr]});
        n_oe = 1'b1;
        n_ce = 1'b1;
        step(L + 1);
        check({tag, "_oe_hold"}, {31'd0, data_oe}, 32'd1);
        step(1);
        check({tag, "_oe_off"}, {31'd0, data_oe}, 32'd0);
    endtask

    task automatic read_check(input logic [7:0] a, input string tag);
        set_addr(a);
        read_here(tag);
    endtask

    initial begin
        step(3);
        check("rst_addr", {24'd0, addr}, 32'd0);
        check("rst_oe", {31'd0, data_oe}, 32'd0);
        check("rst_dout", {24'd0, data_out}, 32'd0);
        check("rst_cont", {31'd0, contention}, 32'd0);
        n_reset = 1'b1;
        step(2);

        for (int i = 0; i < 3; i++) pulse_count();
        step(L + 1);
        check("cnt3_addr", {24'd0, addr}, {24'd0, ref_addr});
        check("cnt3_oe", {31'd0, data_oe}, 32'd0);
        check("cnt3_cont", {31'd0, contention}, 32'd0);
        clear_addr();
        check("clr_addr", {24'd0, addr}, {24'd0, ref_addr});

        write_word(8'd5, 8'hA5);
        check("w5_addr", {24'd0, addr}, 32'd5);
        read_here("r5");

        for (int k = 0; k < 6; k++) begin
            rnd_a[k] = 8'(10 + 8 * k + $urandom_range(0, 7));
            rnd_d[k] = 8'($urandom);
            write_word(rnd_a[k], rnd_d[k]);
        end
        for (int k = 5; k >= 0; k--) read_check(rnd_a[k], $sformatf("rnd%0d", k));

        write_word(8'd0, 8'h3C);
        clear_addr();
        for (int i = 0; i < 256; i++) pulse_count();
        step(L + 1);
        check("wrap_addr", {24'd0, addr}, {24'd0, ref_addr});
        write_word(8'd255, 8'hC3);
        pulse_count();
        step(L + 1);
        check("wrap_inc", {24'd0, addr}, 32'd0);
        read_here("wrap_r0");
        read_check(8'd255, "r255");

        set_addr(8'd7);
        load_hold(8'h5A);
        n_ce = 1'b0;
        n_oe = 1'b0;
        n_we = 1'b0;
        for (int i = 0; i < L + 4; i++) begin
            step(1);
            check($sformatf("wr_oe_low%0d", i), {31'd0, data_oe}, 32'd0);
        end
        n_we = 1'b1;
        step(L + 3);
        n_ce = 1'b1;
        n_oe = 1'b1;
        step(L + 3);
        ref_mem[7] = 8'h5A;
        read_check(8'd7, "r7");

        set_addr(8'd5);
        n_ce = 1'b0;
        n_oe = 1'b0;
        step(L + 3);
        check("cont_pre", {31'd0, contention}, {31'd0, ref_cont});
        de = 1'b1;
        step(L + 2);
        ref_cont = 1'b1;
        check("cont_set", {31'd0, contention}, {31'd0, ref_cont});
        de = 1'b0;
        step(L + 3);
        check("cont_sticky", {31'd0, contention}, {31'd0, ref_cont});
        n_ce = 1'b1;
        n_oe = 1'b1;
        step(L + 3);
        check("cont_idle", {31'd0, contention}, {31'd0, ref_cont});

        set_addr(8'd5);
        load_hold(8'hFF);
        n_ce = 1'b0;
        n_we = 1'b0;
        step(L + 3);
        n_reset = 1'b0;
        step(1);
        ref_cont = 1'b0;
        ref_addr = 8'd0;
        check("mrst_addr", {24'd0, addr}, 32'd0);
        check("mrst_oe", {31'd0, data_oe}, 32'd0);
        check("mrst_dout", {24'd0, data_out}, 32'd0);
        check("mrst_cont", {31'd0, contention}, {31'd0, ref_cont});
        n_we = 1'b1;
        n_ce = 1'b1;
        step(L + 3);
        n_reset = 1'b1;
        step(2);
        read_check(8'd5, "mrst_r5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_responder.md
# sram_responder

Cycle-based model of the external SRAM board: address counter, data latch and asynchronous SRAM array, driven by the same control pins the SRAM controller puts on GPIO. It sits at the far end of those pins, either on a second FPGA or in simulation as the responder for the controller. It samples the controller's strobes on its own clock, answers reads by driving a data bus, commits writes into an internal array and flags bus contention.

## Interface
- ADDR_W, 8, address counter and array depth (2^ADDR_W words)
- DATA_W, 8, data word width
- clock  in  1  sampling clock; all state on rising edge
- n_reset  in  1  asynchronous, active-low reset
- count  in  1  address counter increment strobe (rising edge counts)
- latch  in  1  data-latch strobe (rising edge captures data_in into hold register)
- de  in  1  controller data-drive enable, active-high
- n_de  in  1  controller data-drive enable, active-low
- n_ce  in  1  chip enable, active-low
- n_oe  in  1  output enable, active-low
- n_we  in  1  write enable, active-low
- rst  in  1  counter clear, active-high
- n_rst  in  1  counter clear, active-low
- data_in  in  DATA_W  bus value driven by controller
- data_out  out  DATA_W  read data toward controller
- data_oe  out  1  responder is driving data_out
- addr  out  ADDR_W  current counter value
- contention  out  1  sticky: both ends drove the bus

## Operation
- All pin inputs pass through the input stage (see Configuration) giving s_* signals; edges are computed on s_* against their previous-cycle values.
- Counter: clear when s_rst==1 or s_n_rst==0 (clear wins over count in the same cycle); else on s_count rising edge, addr <= addr+1 mod 2^ADDR_W (255 -> 0 at ADDR_W=8).
- Hold register: on s_latch rising edge, hold <= s_data_in.
- FSM states IDLE, READ, WRITE:
  - IDLE: s_n_ce==0 && s_n_we==0 -> WRITE, waddr <= addr; else s_n_ce==0 && s_n_oe==0 -> READ; else stay.
  - READ: data_out <= mem[addr] every cycle, data_oe=1. s_n_we==0 (with s_n_ce==0) -> WRITE (write wins over output enable); s_n_ce==1 or s_n_oe==1 -> IDLE.
  - WRITE: data_oe=0. Exit when s_n_we==1 or s_n_ce==1: mem[waddr] <= hold, go IDLE. Counter keeps running during WRITE; the commit address stays waddr.
- contention set when data_oe==1 and (s_de==1 or s_n_de==0). It clears only on reset.
- Reset: state IDLE, addr 0, hold 0, data_out 0, data_oe 0, contention 0. Array contents are not reset.
- Reset mid-WRITE: no commit is performed.

## Timing
- L = input-stage latency: 2 cycles with the macro, 0 without.
- READ entry is L+1 cycles after the n_ce/n_oe pin edge. data_oe and valid data_out appear on the following cycle; data_out tracks addr changes one cycle later.
- data_oe deasserts 1 cycle after the FSM leaves READ.
- Write commit happens on the cycle the FSM leaves WRITE, L+1 after the n_we rising pin edge. A read of that address is valid from the next cycle.
- Count edges closer than 2 cycles apart on the pin are not guaranteed to be counted separately.

## Configuration
- SRAM_RESPONDER_SYNC_EN defined: every pin input gets a two-flop synchronizer (reset to the inactive level: n_* =1, others 0). This is required when the pins come from another clock domain.
- Not defined: inputs are used directly (L=0). This is for a same-clock simulation only.

## Structure
- Package sram_pkg holds:
  - default ADDR_W/DATA_W
  - FSM state encoding (IDLE=2'd0, READ=2'd1, WRITE=2'd2)
  - pin inactive-level constants
- Sub-module sync_edge: a per-bit synchronizer (bypassed without the macro) plus previous-value register. It outputs the level, rise and fall. It is instantiated once per control pin.
- The array is an inferred register/RAM inside the top module.

## Test plan
- Reset, then 3 count pulses -> addr=3, data_oe=0, contention=0. Then rst pulse with a simultaneous count -> addr=0.
- Write sequence: addr=5, data_in=0xA5, latch pulse, n_ce=0, n_we=0 then n_we=1 -> mem[5]=0xA5. Then n_oe=0 -> data_out=0xA5 with data_oe=1 at the specified cycle.
- Counter wrap: 256 count pulses from addr=0 -> addr=0. Write at 255, count once, read -> addr 0 data unchanged.
- n_oe=0 and n_we=0 asserted together with n_ce=0 -> WRITE entered, data_oe stays 0, commit on n_we release.
- While READ is active, assert de=1 -> contention=1, and it remains 1 after de=0 until n_reset.
- n_reset pulled low during WRITE -> no array update at waddr, all outputs at reset values.
